// File: rtl/pwm_gen.sv
// Edge-aligned complementary PWM with shadowed duty, dead time,
// and mid-period ADC trigger.
module pwm_gen #(
    parameter int PARAMETER_BIT_WIDTH = 26,
    parameter int PERIOD_BIT_WIDTH    = 21,
    parameter int PERIOD              = 1000,
    parameter int DEAD_TIME           = 10,
    parameter int TRIG_POINT          = 500
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic signed [PARAMETER_BIT_WIDTH-1:0] duty,
    output logic                                  pwm_h,
    output logic                                  pwm_l,
    output logic                                  adc_trig,
    output logic                                  period_start,
    output logic        [PERIOD_BIT_WIDTH-1:0]    duty_active
);

    localparam int PW = PARAMETER_BIT_WIDTH;
    localparam int CW = PERIOD_BIT_WIDTH;

    localparam logic [CW-1:0]        LAST  = CW'(PERIOD - 1);
    localparam logic [CW-1:0]        PER   = CW'(PERIOD);
    localparam logic [CW-1:0]        DT    = CW'(DEAD_TIME);
    localparam logic [CW-1:0]        TRIG  = CW'(TRIG_POINT);
    localparam logic signed [PW-1:0] PER_S = PW'(PERIOD);

    logic [CW-1:0] cnt;
    logic [CW-1:0] dc;
    logic [CW-1:0] h_run;
    logic [CW-1:0] l_run;
    logic [CW-1:0] h_sat;
    logic [CW-1:0] l_sat;
    logic          raw;
    logic          wrap;

    always_comb begin
        dc = '0;
        if (duty[PW-1]) begin
            dc = '0;
        end else if (duty > PER_S) begin
            dc = PER;
        end else begin
            dc = duty[CW-1:0];
        end
    end

    // Run lengths count prior consecutive cycles at the same raw level,
    // saturating once the dead time is covered.
    always_comb begin
        raw   = cnt < duty_active;
        wrap  = cnt == LAST;
        h_sat = (h_run == DT) ? DT : h_run + 1'b1;
        l_sat = (l_run == DT) ? DT : l_run + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            duty_active  <= '0;
            h_run        <= '0;
            l_run        <= '0;
            pwm_h        <= 1'b0;
            pwm_l        <= 1'b0;
            adc_trig     <= 1'b0;
            period_start <= 1'b0;
        end else if (!en) begin
            cnt          <= '0;
            duty_active  <= dc;
            h_run        <= '0;
            l_run        <= '0;
            pwm_h        <= 1'b0;
            pwm_l        <= 1'b0;
            adc_trig     <= 1'b0;
            period_start <= 1'b0;
        end else begin
            cnt          <= wrap ? '0 : cnt + 1'b1;
            if (wrap) begin
                duty_active <= dc;
            end
            h_run        <= raw ? h_sat : '0;
            l_run        <= raw ? '0 : l_sat;
            pwm_h        <= raw && (h_run == DT);
            pwm_l        <= !raw && (l_run == DT);
            adc_trig     <= cnt == TRIG;
            period_start <= cnt == '0;
        end
    end

endmodule

// File: tb/tb_pwm_gen.sv
// Bench for pwm_gen: directed scenarios then random stimulus, checked
// cycle by cycle against a raw-history reference model.
module tb_pwm_gen;

    localparam int P  = 20;
    localparam int T  = 2;
    localparam int TP = 10;

    logic               clk;
    logic               rst;
    logic               en;
    logic signed [25:0] duty;
    logic               pwm_h;
    logic               pwm_l;
    logic               adc_trig;
    logic               period_start;
    logic [20:0]        duty_active;

    int npass = 0;
    int ntot  = 0;

    int m_cnt;
    int m_da;
    bit m_h;
    bit m_l;
    bit m_trig;
    bit m_ps;
    bit hist[$];

    pwm_gen #(
        .PARAMETER_BIT_WIDTH(26),
        .PERIOD_BIT_WIDTH(21),
        .PERIOD(P),
        .DEAD_TIME(T),
        .TRIG_POINT(TP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .duty(duty),
        .pwm_h(pwm_h),
        .pwm_l(pwm_l),
        .adc_trig(adc_trig),
        .period_start(period_start),
        .duty_active(duty_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clampd(int d);
        if (d < 0) return 0;
        if (d > P) return P;
        return d;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Model advances one clock from current inputs, then DUT is compared.
    task automatic tick();
        bit raw;
        bit all1;
        bit all0;
        int nda;
        if (rst || !en) begin
            m_da   = rst ? 0 : clampd(int'(duty));
            m_cnt  = 0;
            hist.delete();
            m_h    = 0;
            m_l    = 0;
            m_trig = 0;
            m_ps   = 0;
        end else begin
            raw = m_cnt < m_da;
            hist.push_back(raw);
            if (hist.size() > T + 1) void'(hist.pop_front());
            all1 = hist.size() == T + 1;
            all0 = all1;
            foreach (hist[i]) begin
                if (!hist[i]) all1 = 0;
                if (hist[i]) all0 = 0;
            end
            m_h    = all1;
            m_l    = all0;
            m_trig = m_cnt == TP;
            m_ps   = m_cnt == 0;
            nda    = (m_cnt == P - 1) ? clampd(int'(duty)) : m_da;
            m_cnt  = (m_cnt + 1) % P;
            m_da   = nda;
        end
        @(posedge clk);
        #1;
        chk("pwm_h", 32'(pwm_h), 32'(m_h));
        chk("pwm_l", 32'(pwm_l), 32'(m_l));
        chk("adc_trig", 32'(adc_trig), 32'(m_trig));
        chk("period_start", 32'(period_start), 32'(m_ps));
        chk("duty_active", 32'(duty_active), 32'(m_da));
        chk("no_overlap", 32'(pwm_h & pwm_l), 32'd0);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to_cnt(int v);
        for (int i = 0; i < P + 1 && m_cnt != v; i++) tick();
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b1;
        duty = 26'sd8;
        m_cnt = 0;
        m_da  = 0;
        #2;
        run(2);
        rst = 1'b0;
        run(3 * P);

        run_to_cnt(5);
        duty = 26'sd12;
        run(2 * P + 5);

        duty = -26'sd5;
        run(2 * P + 5);
        duty = 26'sd25;
        run(2 * P + 5);

        duty = 26'sd2;
        run(2 * P + 5);

        duty = 26'sd8;
        run(2 * P);
        run_to_cnt(6);
        en = 1'b0;
        run(2);
        en = 1'b1;
        run(2 * P + 5);

        run_to_cnt(6);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(2 * P + 5);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0)
                duty = 26'(int'($urandom_range(0, 40)) - 10);
            en  = $urandom_range(0, 59) != 0;
            rst = $urandom_range(0, 199) == 0;
            tick();
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/pwm_gen.md
# pwm_gen

Edge-aligned complementary PWM generator that sits directly downstream of the PI controller: it consumes the signed controller output as a duty command and drives a half-bridge high/low gate pair with programmable dead time. Duty updates are shadowed and take effect only at period boundaries. It also emits a mid-period ADC trigger that starts the next conversion feeding the controller's sample path.

## Interface
- PARAMETER_BIT_WIDTH, 26: width of the signed duty command.
- PERIOD_BIT_WIDTH, 21: width of the period counter and duty shadow.
- PERIOD, 1000: PWM period in clk cycles; legal range 2 ≤ PERIOD < 2^PERIOD_BIT_WIDTH.
- DEAD_TIME, 10: dead time in clk cycles; legal range 0 ≤ DEAD_TIME < PERIOD.
- TRIG_POINT, 500: counter value that fires adc_trig; must be < PERIOD.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable.
- duty  in  PARAMETER_BIT_WIDTH, signed  duty command in counts (from the controller output).
- pwm_h  out  1  high-side gate drive.
- pwm_l  out  1  low-side gate drive.
- adc_trig  out  1  one-cycle ADC start pulse.
- period_start  out  1  one-cycle pulse marking counter value 0.
- duty_active  out  PERIOD_BIT_WIDTH  duty currently in effect (debug/monitor).

## Operation
- Reset: cnt=0, duty_active=0, raw history cleared. pwm_h, pwm_l, adc_trig, period_start are all 0.
- Counter: while en=1, cnt increments by 1 each cycle and wraps from PERIOD-1 to 0. While en=0, cnt holds at 0.
- Clamp: dc = 0 if duty<0; PERIOD if duty>PERIOD; else duty. Compare signed at PARAMETER_BIT_WIDTH with PERIOD zero-extended. No truncation before the clamp.
- Shadow load: duty_active <= dc when en=0, or when en=1 and cnt==PERIOD-1. Otherwise duty_active holds. A new duty therefore always starts a fresh period at cnt=0.
- Raw drive: raw(k) = (cnt < duty_active) in cycle k.
- Dead time: pwm_h is 1 in cycle k+1 iff raw was 1 in each of cycles k-DEAD_TIME..k since the last reset or en=0. pwm_l is the same with raw=0. The two outputs are never 1 together.
  - DEAD_TIME=0: pwm_l = ~pwm_h while running.
  - If an on-phase or off-phase is ≤ DEAD_TIME cycles long, the corresponding output stays 0 for that phase (pulse swallowed).
- duty_active=0: pwm_h never asserts, and pwm_l stays 1 continuously across period wraps. duty_active=PERIOD: the mirror case.
- en=0: pwm_h=0, pwm_l=0, adc_trig=0, period_start=0 from the next cycle, and raw history is cleared. Re-enabling behaves exactly like release from reset.
- adc_trig: 1 in cycle k+1 iff en=1 and cnt==TRIG_POINT in cycle k.
- period_start: 1 in cycle k+1 iff en=1 and cnt==0 in cycle k.
- Reset mid-period takes priority over everything and gives the reset state on the next cycle.

## Timing
- All outputs are registered, with 1 cycle of latency from the cnt value that causes them.
- A duty change reaches the outputs within at most PERIOD+1 cycles. A sample captured at cnt==PERIOD-1 is first compared at cnt=0 and appears on pwm_h one cycle later.
- Within one period with 0<D<PERIOD and T=DEAD_TIME:
  - pwm_h is high for the cycles following cnt = T..D-1 (D-T cycles if D>T).
  - pwm_l is high for the cycles following cnt = D+T..PERIOD-1, and stays high across the wrap only if the next raw is 0.
- After reset release or en rising (cycle 0 = first active cycle, cnt=0), the first output assertion is at cycle DEAD_TIME+1 at the earliest.
- adc_trig and period_start are each exactly one cycle wide, once per period.

## Test plan
- PERIOD=20, DEAD_TIME=2, duty=8, en=1 after reset → each period: pwm_h high 6 cycles (after cnt 2..7), pwm_l high 10 cycles (after cnt 10..19), both low 2 cycles at each edge, never overlapping.
- Clamp: duty=-5 → duty_active=0, pwm_l continuously high after the initial 3 cycles. duty=25 → duty_active=20, pwm_h continuously high.
- Shadow: change duty 8→12 at cnt=5 → current period keeps the 6-cycle pwm_h, next period shows 10 cycles. duty_active changes only in the cycle after cnt=19.
- Pulse swallow: DEAD_TIME=2, duty=2 → pwm_h never asserts, pwm_l high after cnt 4..19.
- adc_trig/period_start: TRIG_POINT=10 → adc_trig exactly 1 cycle after cnt=10 and period_start 1 cycle after cnt=0, spaced 20 cycles apart.
- Assert rst or drop en at cnt=6 mid-on-phase → all outputs 0 next cycle, cnt=0. Re-enable with duty=8 → same waveform as the first scenario from cycle 0.
